// File: rtl/mac_unit_vert_seq.sv
// Vertical bit-column MAC: one weight bit-column per beat (MSB first), a 2-stage
// accumulate pipeline, and a saturated, rescaled result behind a valid/ready handshake.
module mac_unit_vert_seq #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 32,
    parameter int MAX_COL       = 8,
    parameter int SUM_ACT_WIDTH = DATA_WIDTH + 3,
    parameter int ACC_WIDTH     = 32,
    parameter int RESULT_WIDTH  = 16,
    parameter int OUT_SHIFT     = 8,
    localparam int NUM_GROUPS   = VEC_LENGTH / 8,
    localparam int NUM_LANES    = VEC_LENGTH / 2,
    localparam int COL_WIDTH    = $clog2(MAX_COL)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [COL_WIDTH:0]                          cfg_num_col,
    input  logic                                        load_accum,
    input  logic [ACC_WIDTH-1:0]                        accum_prev,
    input  logic                                        col_valid,
    output logic                                        col_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]       act_in,
    input  logic [NUM_LANES-1:0][2:0]                   act_sel,
    input  logic [NUM_LANES-1:0]                        act_val,
    input  logic [NUM_GROUPS-1:0][SUM_ACT_WIDTH-1:0]    sum_act,
    input  logic [NUM_GROUPS-1:0]                       is_skip_zero,
    input  logic [2:0]                                  mul_const,
    input  logic                                        is_shift_mul,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [RESULT_WIDTH-1:0]                     result,
    output logic                                        result_sat,
    output logic                                        busy,
    output logic [1:0]                                  dbg_state
);

    // Handshakes: a column beat transfers on a clk edge where col_valid && col_ready;
    // a result transfers on a clk edge where out_valid && out_ready. out_valid, result
    // and result_sat stay stable until that transfer.

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

    localparam logic [COL_WIDTH:0] NCOL_ONE = (COL_WIDTH+1)'(1);
    localparam logic [COL_WIDTH:0] NCOL_TWO = (COL_WIDTH+1)'(2);
    localparam logic [COL_WIDTH:0] NCOL_MAX = (COL_WIDTH+1)'(MAX_COL);
    localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN =
        {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

    state_t                        state_q, state_d;
    logic [COL_WIDTH:0]            ncol_q, ncol_d;
    logic [COL_WIDTH-1:0]          col_idx_q, col_idx_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          s1_valid_q, s1_valid_d;
    logic signed [ACC_WIDTH-1:0]   s1_term_q, s1_term_d;
    logic signed [ACC_WIDTH-1:0]   s1_mul_q, s1_mul_d;
    logic                          out_valid_q, out_valid_d;
    logic [RESULT_WIDTH-1:0]       result_q, result_d;
    logic                          result_sat_q, result_sat_d;

    logic signed [ACC_WIDTH-1:0]   lane_val [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]   grp_true [NUM_GROUPS];
    logic signed [ACC_WIDTH-1:0]   sa_ext   [NUM_GROUPS];
    logic signed [ACC_WIDTH-1:0]   tot_chain [NUM_GROUPS+1];
    logic signed [ACC_WIDTH-1:0]   sa_chain  [NUM_GROUPS+1];

    assign tot_chain[0] = '0;
    assign sa_chain[0]  = '0;

    // Each lane picks one of five activations from its group's 8-wide window.
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        logic signed [ACC_WIDTH-1:0] psum;
        for (genvar j = 0; j < 4; j++) begin : g_lane
            localparam int L = 4*g + j;
            localparam int B = 8*g + j;
            logic [DATA_WIDTH-1:0] picked;
            assign picked = (act_sel[L] == 3'd0) ? act_in[B]   :
                            (act_sel[L] == 3'd1) ? act_in[B+1] :
                            (act_sel[L] == 3'd2) ? act_in[B+2] :
                            (act_sel[L] == 3'd3) ? act_in[B+3] :
                            (act_sel[L] == 3'd4) ? act_in[B+4] : '0;
            assign lane_val[L] = act_val[L] ? ACC_WIDTH'($signed(picked)) : '0;
        end
        assign psum         = lane_val[4*g] + lane_val[4*g+1] + lane_val[4*g+2] + lane_val[4*g+3];
        assign sa_ext[g]    = ACC_WIDTH'($signed(sum_act[g]));
        assign grp_true[g]  = is_skip_zero[g] ? psum : sa_ext[g] - psum;
        assign tot_chain[g+1] = tot_chain[g] + grp_true[g];
        assign sa_chain[g+1]  = sa_chain[g] + sa_ext[g];
    end

    logic                          beat;
    logic [COL_WIDTH:0]            ncol_cfg;
    logic [COL_WIDTH:0]            ncol_eff;
    logic [COL_WIDTH:0]            ncol_m1;
    logic [COL_WIDTH:0]            ncol_m2;
    logic [COL_WIDTH-1:0]          cur_idx;
    logic                          cur_msb;
    logic signed [ACC_WIDTH-1:0]   tot_signed;
    logic signed [ACC_WIDTH-1:0]   beat_term;
    logic signed [ACC_WIDTH-1:0]   mc_ext;
    logic signed [ACC_WIDTH-1:0]   mul_prod;
    logic signed [ACC_WIDTH-1:0]   mul_term;
    logic signed [ACC_WIDTH-1:0]   acc_sh;

    assign col_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign beat      = col_valid && col_ready;

    always_comb begin
        ncol_cfg = cfg_num_col;
        if (cfg_num_col == '0) begin
            ncol_cfg = NCOL_ONE;
        end else if (cfg_num_col > NCOL_MAX) begin
            ncol_cfg = NCOL_MAX;
        end
        ncol_eff = (state_q == S_IDLE) ? ncol_cfg : ncol_q;
        ncol_m1  = ncol_eff - NCOL_ONE;
        ncol_m2  = ncol_cfg - NCOL_TWO;

        // The first beat of a tile is always the MSB column.
        cur_idx  = (state_q == S_IDLE) ? ncol_m1[COL_WIDTH-1:0] : col_idx_q;
        cur_msb  = ({1'b0, cur_idx} == ncol_m1);

        tot_signed = cur_msb ? -tot_chain[NUM_GROUPS] : tot_chain[NUM_GROUPS];
        beat_term  = tot_signed <<< cur_idx;
        mc_ext     = {{(ACC_WIDTH-3){1'b0}}, mul_const};
        mul_prod   = sa_chain[NUM_GROUPS] * mc_ext;
        mul_term   = is_shift_mul ? (mul_prod <<< 3) : mul_prod;

        acc_sh     = acc_q >>> OUT_SHIFT;
    end

    always_comb begin
        state_d      = state_q;
        ncol_d       = ncol_q;
        col_idx_d    = col_idx_q;
        acc_d        = s1_valid_q ? (acc_q + s1_term_q + s1_mul_q) : acc_q;
        s1_valid_d   = beat;
        s1_term_d    = beat ? beat_term : s1_term_q;
        s1_mul_d     = beat ? mul_term  : s1_mul_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        result_sat_d = result_sat_q;

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    ncol_d = ncol_cfg;
                    acc_d  = load_accum ? $signed(accum_prev) : '0;
                    if (ncol_cfg == NCOL_ONE) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d   = S_ACCUM;
                        col_idx_d = ncol_m2[COL_WIDTH-1:0];
                    end
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    if (col_idx_q == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        col_idx_d = col_idx_q - 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Wait until the last stage-1 value has landed in the accumulator.
                if (!s1_valid_q) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    if (acc_sh > RES_MAX) begin
                        result_d     = RES_MAX[RESULT_WIDTH-1:0];
                        result_sat_d = 1'b1;
                    end else if (acc_sh < RES_MIN) begin
                        result_d     = RES_MIN[RESULT_WIDTH-1:0];
                        result_sat_d = 1'b1;
                    end else begin
                        result_d     = acc_sh[RESULT_WIDTH-1:0];
                        result_sat_d = 1'b0;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ncol_q       <= '0;
            col_idx_q    <= '0;
            acc_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_term_q    <= '0;
            s1_mul_q     <= '0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            result_sat_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ncol_q       <= ncol_d;
            col_idx_q    <= col_idx_d;
            acc_q        <= acc_d;
            s1_valid_q   <= s1_valid_d;
            s1_term_q    <= s1_term_d;
            s1_mul_q     <= s1_mul_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            result_sat_q <= result_sat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign result_sat = result_sat_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// Directed bench for mac_unit_vert_seq: a table of whole-tile vectors plus
// hand-written latency, backpressure and mid-tile reset sequences.
module tb_mac_unit_vert_seq;

    localparam int DW  = 8;
    localparam int VL  = 32;
    localparam int SAW = 11;
    localparam int AW  = 32;
    localparam int RW  = 16;
    localparam int NG  = 4;
    localparam int NL  = 16;
    localparam int CW  = 3;
    localparam int NV  = 17;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [CW:0]              cfg_num_col;
    logic                     load_accum;
    logic [AW-1:0]            accum_prev;
    logic                     col_valid;
    logic                     col_ready;
    logic [VL-1:0][DW-1:0]    act_in;
    logic [NL-1:0][2:0]       act_sel;
    logic [NL-1:0]            act_val;
    logic [NG-1:0][SAW-1:0]   sum_act;
    logic [NG-1:0]            is_skip_zero;
    logic [2:0]               mul_const;
    logic                     is_shift_mul;
    logic                     out_valid;
    logic                     out_ready;
    logic [RW-1:0]            result;
    logic                     result_sat;
    logic                     busy;
    logic [1:0]               dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    mac_unit_vert_seq #(
        .DATA_WIDTH(DW), .VEC_LENGTH(VL), .MAX_COL(8), .SUM_ACT_WIDTH(SAW),
        .ACC_WIDTH(AW), .RESULT_WIDTH(RW), .OUT_SHIFT(0)
    ) dut (
        .clk(clk), .reset(reset), .cfg_num_col(cfg_num_col), .load_accum(load_accum),
        .accum_prev(accum_prev), .col_valid(col_valid), .col_ready(col_ready),
        .act_in(act_in), .act_sel(act_sel), .act_val(act_val), .sum_act(sum_act),
        .is_skip_zero(is_skip_zero), .mul_const(mul_const), .is_shift_mul(is_shift_mul),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_sat(result_sat), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ncol;
        bit          ramp;      // 1: act_in[i] = i, 0: every activation = actu
        int          actu;
        int          sel;
        logic [15:0] mask;
        logic [3:0]  skip;
        int          sa;
        int          mc;
        bit          shm;
        bit          load;
        int          prev;
        int          gap;
        int          exp_res;
        bit          exp_sat;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] ncol, input bit ramp, input int actu,
                                input int sel, input logic [15:0] mask, input logic [3:0] skip,
                                input int sa, input int mc, input bit shm, input bit load,
                                input int prev, input int gap, input int exp_res,
                                input bit exp_sat);
        vec_t v;
        v.ncol = ncol; v.ramp = ramp; v.actu = actu; v.sel = sel; v.mask = mask;
        v.skip = skip; v.sa = sa; v.mc = mc; v.shm = shm; v.load = load; v.prev = prev;
        v.gap = gap; v.exp_res = exp_res; v.exp_sat = exp_sat;
        return v;
    endfunction

    function automatic int num_beats(input logic [3:0] ncol);
        if (ncol == 4'd0) return 1;
        if (ncol > 4'd8) return 8;
        return int'(ncol);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        cfg_num_col = v.ncol;
        load_accum  = v.load;
        accum_prev  = AW'(v.prev);
        for (int i = 0; i < VL; i++) act_in[i] = v.ramp ? DW'(i) : DW'(v.actu);
        for (int l = 0; l < NL; l++) begin
            act_sel[l] = 3'(v.sel);
            act_val[l] = v.mask[l];
        end
        for (int g = 0; g < NG; g++) sum_act[g] = SAW'(v.sa);
        is_skip_zero = v.skip;
        mul_const    = 3'(v.mc);
        is_shift_mul = v.shm;
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_beat(input vec_t v, input string name);
        int t = 0;
        apply(v);
        col_valid = 1'b1;
        while (!col_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!col_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_accept: col_ready stuck at 0 for %0d cycles, required 1", name, t);
        end
        @(posedge clk);
        @(negedge clk);
        col_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: out_valid stayed 0 for 40 cycles, required 1", name);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_tile(input vec_t v, input string name);
        bit ok;
        int nb = num_beats(v.ncol);
        for (int b = 0; b < nb; b++) begin
            if (b > 0) repeat (v.gap) @(negedge clk);
            send_beat(v, name);
        end
        wait_out(name, ok);
        if (ok) begin
            check({name, "_result"}, int'($signed(result)), v.exp_res);
            check({name, "_sat"}, int'(result_sat), int'(v.exp_sat));
            release_out();
        end
    endtask

    initial begin
        vec_t bp;
        vec_t mt;
        //            ncol  rmp act sel mask      skip   sa    mc shm ld prev      gap exp     sat
        vecs[0]  = mk(4'd1,  0,  1,  0, 16'hFFFF, 4'hF,  0,    0, 0, 0, 12345,    0, -16,    0);
        vecs[1]  = mk(4'd2,  0,  2,  0, 16'hFFFF, 4'hF,  0,    0, 0, 0, 0,        0, -32,    0);
        vecs[2]  = mk(4'd1,  0,  1,  0, 16'hFFFF, 4'h0,  100,  5, 1, 0, 0,        0, 15616,  0);
        vecs[3]  = mk(4'd1,  0,  1,  0, 16'h0000, 4'hF,  0,    0, 0, 1, 1000000,  0, 32767,  1);
        vecs[4]  = mk(4'd1,  0,  1,  0, 16'h0000, 4'hF,  0,    0, 0, 1, -1000000, 0, -32768, 1);
        vecs[5]  = mk(4'd0,  0,  1,  0, 16'hFFFF, 4'hF,  0,    0, 0, 0, 0,        0, -16,    0);
        vecs[6]  = mk(4'd15, 0,  1,  0, 16'hFFFF, 4'hF,  0,    0, 0, 0, 0,        0, -16,    0);
        vecs[7]  = mk(4'd1,  1,  0,  0, 16'hFFFF, 4'hF,  0,    0, 0, 0, 0,        0, -216,   0);
        vecs[8]  = mk(4'd1,  1,  0,  4, 16'hFFFF, 4'hF,  0,    0, 0, 0, 0,        0, -280,   0);
        vecs[9]  = mk(4'd1,  1,  0,  5, 16'hFFFF, 4'hF,  0,    0, 0, 0, 0,        0, 0,      0);
        vecs[10] = mk(4'd3,  1,  0,  0, 16'hFFFF, 4'hF,  0,    0, 0, 0, 0,        2, -216,   0);
        vecs[11] = mk(4'd2,  0, -3,  0, 16'hFFFF, 4'hF,  0,    0, 0, 0, 0,        0, 48,     0);
        vecs[12] = mk(4'd1,  0,  1,  0, 16'h00FF, 4'hF,  0,    0, 0, 0, 0,        0, -8,     0);
        vecs[13] = mk(4'd1,  0,  1,  0, 16'hFFFF, 4'hF,  0,    0, 0, 1, 100,      0, 84,     0);
        vecs[14] = mk(4'd1,  0,  1,  0, 16'hFFFF, 4'h0,  -50,  3, 0, 0, 0,        0, -384,   0);
        vecs[15] = mk(4'd1,  0,  0,  0, 16'h0000, 4'hF,  1023, 7, 1, 0, 0,        0, 32767,  1);
        vecs[16] = mk(4'd1,  0,  1,  0, 16'hFFFF, 4'h5,  10,   0, 0, 0, 0,        0, -20,    0);

        reset = 1'b0;
        col_valid = 1'b0;
        out_ready = 1'b0;
        apply(vecs[0]);
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_result_sat", int'(result_sat), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_col_ready", int'(col_ready), 1);
        check("rst_state", int'(dbg_state), 0);
        reset = 1'b1;
        @(negedge clk);

        // Latency: beat accepted at edge E, out_valid must appear only after E+2.
        apply(vecs[0]);
        col_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        col_valid = 1'b0;
        check("lat_after_e0", int'(out_valid), 0);
        @(negedge clk);
        check("lat_after_e1", int'(out_valid), 0);
        @(negedge clk);
        check("lat_after_e2", int'(out_valid), 1);
        check("lat_result", int'($signed(result)), -16);
        release_out();

        for (int i = 0; i < NV; i++) begin
            run_tile(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: the next tile's beat is offered throughout the OUT stall.
        bp = mk(4'd1, 0, 2, 0, 16'hFFFF, 4'hF, 0, 0, 0, 0, 0, 0, -32, 0);
        send_beat(vecs[0], "bp_a");
        begin
            bit ok;
            wait_out("bp_a", ok);
        end
        apply(bp);
        col_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_hold_result_%0d", c), int'($signed(result)), -16);
            check($sformatf("bp_hold_ready_%0d", c), int'(col_ready), 0);
            check($sformatf("bp_hold_valid_%0d", c), int'(out_valid), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_busy", int'(busy), 0);
        check("bp_idle_ready", int'(col_ready), 1);
        @(negedge clk);
        col_valid = 1'b0;
        check("bp_next_accepted", int'(busy), 1);
        begin
            bit ok;
            wait_out("bp_b", ok);
            if (ok) begin
                check("bp_b_result", int'($signed(result)), -32);
                check("bp_b_sat", int'(result_sat), 0);
                release_out();
            end
        end

        // Mid-tile reset after 2 of 4 beats, seeded so any residue would show.
        mt = mk(4'd4, 0, 1, 0, 16'hFFFF, 4'hF, 0, 0, 0, 1, 5000, 0, 0, 0);
        send_beat(mt, "mt");
        send_beat(mt, "mt");
        reset = 1'b0;
        #1;
        check("mt_rst_valid", int'(out_valid), 0);
        check("mt_rst_busy", int'(busy), 0);
        check("mt_rst_ready", int'(col_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("mt_post_valid", int'(out_valid), 0);
        check("mt_post_busy", int'(busy), 0);
        check("mt_post_ready", int'(col_ready), 1);
        run_tile(vecs[0], "mt_fresh");
        run_tile(vecs[10], "mt_fresh3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
